// File: rtl/wd_bus_master.sv
// Host-side bus master for the watchdog: emits AA/55 unlock, four-beat config or
// service window on ABUS/DBUS, auto-kick timer, and WDFAIL/RSTOUT monitoring.
module wd_bus_master #(
  parameter int          UNLOCK_GAP = 2,
  parameter logic [7:0]  KICK_CODE  = 8'h08
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cfg_start,
  input  logic [7:0] frame_len,
  input  logic [7:0] service_len,
  input  logic [7:0] reset_limit,
  input  logic       kick_req,
  input  logic       auto_en,
  input  logic [7:0] kick_period,
  input  logic       WDFAIL,
  input  logic       FLSTAT,
  input  logic       RSTOUT,
  output logic [1:0] ABUS,
  output logic [7:0] DBUS,
  output logic       busy,
  output logic       done,
  output logic [7:0] fail_cnt,
  output logic       fl_status
);

  typedef enum logic [1:0] {IDLE, UNL_AA, UNL_55, WIN} state_t;

  localparam logic [3:0] GAP = 4'(UNLOCK_GAP);

  state_t     state, nxt_state;
  logic [1:0] beat, nxt_beat;
  logic [3:0] gap, nxt_gap;
  logic       op_cfg, nxt_op_cfg;
  logic       start;
  logic       cfg_pend, kick_pend;
  logic [7:0] snap_frame, snap_service, snap_limit;
  logic [7:0] timer;
  logic       timer_run, timer_hit;
  logic       last_beat, kick_fin;
  logic       wdfail_q;
  logic [1:0] abus_d;
  logic [7:0] dbus_d;

  assign last_beat = (state == WIN) && (beat == 2'd3);
  assign kick_fin  = last_beat && !op_cfg;
  assign timer_run = auto_en && (kick_period != 8'd0);
  assign timer_hit = timer_run && (timer == kick_period - 8'd1);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      beat   <= 2'd0;
      gap    <= 4'd0;
      op_cfg <= 1'b0;
      ABUS   <= 2'b00;
      DBUS   <= 8'h00;
      done   <= 1'b0;
    end else begin
      state  <= nxt_state;
      beat   <= nxt_beat;
      gap    <= nxt_gap;
      op_cfg <= nxt_op_cfg;
      ABUS   <= abus_d;
      DBUS   <= dbus_d;
      done   <= last_beat && !RSTOUT;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nxt_state  = state;
    nxt_beat   = beat;
    nxt_gap    = gap;
    nxt_op_cfg = op_cfg;
    start      = 1'b0;
    if (RSTOUT) begin
      nxt_state = IDLE;
      nxt_beat  = 2'd0;
      nxt_gap   = 4'd0;
    end else begin
      unique case (state)
        IDLE:   start = cfg_pend || kick_pend;
        UNL_AA: if (gap == GAP) nxt_state = UNL_55;
                else            nxt_gap   = gap + 4'd1;
        UNL_55: begin
          nxt_state = WIN;
          nxt_beat  = 2'd0;
        end
        WIN: begin
          if (beat == 2'd3) begin
            nxt_state = IDLE;
            start     = cfg_pend || kick_pend;
          end else begin
            nxt_beat = beat + 2'd1;
          end
        end
      endcase
      // Back-to-back: a pending request chains straight from the last beat.
      if (start) begin
        nxt_state  = UNL_AA;
        nxt_gap    = 4'd0;
        nxt_op_cfg = cfg_pend;
      end
    end
  end

  // Bus values are derived from the upcoming state and registered.
  always_comb begin
    abus_d = 2'b00;
    dbus_d = 8'h00;
    unique case (nxt_state)
      IDLE:   begin end
      UNL_AA: dbus_d = 8'hAA;
      UNL_55: dbus_d = 8'h55;
      WIN: begin
        if (nxt_op_cfg) begin
          case (nxt_beat)
            2'd0: begin abus_d = 2'b00; dbus_d = snap_frame;   end
            2'd1: begin abus_d = 2'b01; dbus_d = snap_service; end
            2'd2: begin abus_d = 2'b11; dbus_d = snap_limit;   end
            2'd3: begin abus_d = 2'b10; dbus_d = 8'h00;        end
          endcase
        end else begin
          abus_d = 2'b10;
          dbus_d = (nxt_beat == 2'd0) ? KICK_CODE : 8'h00;
        end
      end
    endcase
  end

  // Pending requests, auto timer and config snapshot. New requests win over the
  // clear of the transaction being launched, so no pulse is ever lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cfg_pend     <= 1'b0;
      kick_pend    <= 1'b0;
      timer        <= 8'd0;
      snap_frame   <= 8'h00;
      snap_service <= 8'h00;
      snap_limit   <= 8'h00;
    end else if (RSTOUT) begin
      cfg_pend  <= 1'b0;
      kick_pend <= 1'b0;
      timer     <= 8'd0;
    end else begin
      cfg_pend  <= (cfg_pend && !start) || cfg_start;
      kick_pend <= (kick_pend && !(start && !cfg_pend)) || kick_req || timer_hit;
      if (!timer_run || kick_fin || timer_hit) timer <= 8'd0;
      else                                     timer <= timer + 8'd1;
      if (start) begin
        snap_frame   <= frame_len;
        snap_service <= service_len;
        snap_limit   <= reset_limit;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdfail_q  <= 1'b0;
      fail_cnt  <= 8'h00;
      fl_status <= 1'b0;
    end else begin
      wdfail_q <= WDFAIL;
      if (WDFAIL && !wdfail_q) begin
        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
        fl_status <= FLSTAT;
      end
    end
  end

endmodule

// File: doc/wd_bus_master.md
# wd_bus_master

Host-side bus master for `watchdog_top`. It generates the ABUS/DBUS traffic the watchdog decodes: the AA/55 unlock pattern, the four-beat configuration write window, and service kicks, either on request or from an internal periodic timer. It also monitors WDFAIL/FLSTAT/RSTOUT and aborts traffic when the watchdog resets the system. It sits between the system controller logic and the watchdog's ABUS/DBUS inputs.

## Interface

Parameters:
- UNLOCK_GAP, 2: extra cycles DBUS holds 8'hAA after the first AA beat (0..15).
- KICK_CODE, 8'h08: DBUS value of the service beat.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- cfg_start  in  1  one-cycle request for a configuration transaction.
- frame_len  in  8  frame window length, sampled at transaction start.
- service_len  in  8  service window length, sampled at transaction start.
- reset_limit  in  8  reset-limit value, sampled at transaction start.
- kick_req  in  1  one-cycle request for a service transaction.
- auto_en  in  1  enables periodic kicks.
- kick_period  in  8  auto-kick interval in cycles; 0 disables auto-kick.
- WDFAIL  in  1  watchdog fail flag.
- FLSTAT  in  1  watchdog fail status.
- RSTOUT  in  1  watchdog reset output.
- ABUS  out  2  watchdog address bus, registered.
- DBUS  out  8  watchdog data bus, registered.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse, transaction completed.
- fail_cnt  out  8  saturating count of WDFAIL rising edges.
- fl_status  out  1  FLSTAT captured on WDFAIL rising edge.

## Operation

- States: IDLE, UNL_AA, UNL_55, WIN (2-bit beat index 0..3), plus op flag CFG/KICK.
- Idle bus: ABUS=2'b00, DBUS=8'h00.
- UNL_AA: ABUS=00, DBUS=AA for 1+UNLOCK_GAP cycles. UNL_55: ABUS=00, DBUS=55, 1 cycle.
- CFG window beats 0..3: (00, frame_len), (01, service_len), (11, reset_limit), (10, 00).
- KICK window beats 0..3: (10, KICK_CODE), (10, 00), (10, 00), (10, 00).
- Transaction length: 6+UNLOCK_GAP cycles (8 by default).
- Requests: cfg_start and kick_req set sticky pending bits (cfg_pend, kick_pend) in any state; pulses arriving while busy are never lost, repeats merge.
- Arbitration: cfg_pend beats kick_pend. The pending bit clears when its transaction enters UNL_AA. frame_len/service_len/reset_limit are snapshotted at that cycle.
- After WIN beat 3: done=1 for one cycle. If any bit is pending, UNL_AA starts in that same cycle with no idle gap; otherwise the block goes to IDLE.
- Auto timer: 8-bit counter, runs while auto_en=1 and kick_period!=0, else held at 0. When it reaches kick_period-1 it sets kick_pend and wraps to 0. Any KICK completion also clears it to 0.
- Monitor: WDFAIL rising edge (registered compare) increments fail_cnt, saturating at 8'hFF, and loads fl_status<=FLSTAT.
- RSTOUT=1 (synchronous sample) forces IDLE next cycle, idle bus, clears both pending bits and the auto timer, and holds them clear while high. done is not pulsed. fail_cnt and fl_status are kept.
- busy=1 in every non-IDLE state.

## Timing

- Reset values: ABUS=00, DBUS=00, busy=0, done=0, fail_cnt=0, fl_status=0. State IDLE, pending bits 0, timer 0.
- Latency: a request sampled at edge k in IDLE puts AA on the bus after edge k+1; busy rises at the same time.
- All outputs change only on the rising CLK edge, except asynchronous RST.
- A request arriving in the same cycle as RSTOUT=1 is dropped.
- Reset asserted mid-transaction returns everything to reset values immediately.

## Test plan

- Reset: assert RST asynchronously mid-cycle → all outputs are 0 at once; after release the bus stays 00/00.
- Config: cfg_start with 0A/03/04 → bus sequence (00,AA)×3, (00,55), (00,0A), (01,03), (11,04), (10,00), then done for one cycle and busy falls.
- Simultaneous: cfg_start and kick_req in the same cycle → full CFG transaction, then KICK begins in the done cycle with (00,AA), then (10,08) beat; two done pulses 8 cycles apart.
- Auto-kick: auto_en=1, kick_period=20 → KICK transactions start every 20 cycles after timer reset; kick_period=0 → no traffic.
- Abort: RSTOUT=1 during the WIN beat 1 of CFG → bus returns to 00/00 next cycle, no done pulse, and a pending kick is discarded.
- Monitor: 300 WDFAIL pulses with FLSTAT=1 on the last → fail_cnt=FF (saturated), fl_status=1.
